// File: rtl/imm_ext_pipe.sv
// -----------------------------------------------------------------------------
// imm_ext_pipe
//   Pipelined immediate generator for the ID/EX boundary. The immediate-bearing
//   fields of an instruction are decoded into a DATA_W-wide operand in one of
//   six modes (zero, sign, lui, shamt, branch offset, jump target). Each entry
//   {operand, tag, err} is registered behind a valid/ready handshake.
//
//   Optional feature macro: IMM_EXT_PIPE_SKID_EN
//     defined   : two-entry skid buffer (output reg + skid reg); in_ready is a
//                 register output, with no combinational path from out_ready.
//     undefined : single output register; in_ready = !out_valid || out_ready.
//
// Parameters
//   DATA_W : operand width (32 or 64)
//   TAG_W  : side-band tag width
//
// Ports
//   clk        in   clock, rising edge
//   reset      in   asynchronous active-high reset
//   in_valid   in   input instruction valid
//   in_ready   out  stage accepts input this cycle
//   Instr      in   [31:0]       instruction word
//   PCPlus4    in   [DATA_W-1:0] PC+4 of the instruction
//   ImmMode    in   [2:0]        extension mode (6,7 illegal)
//   in_tag     in   [TAG_W-1:0]  side-band tag
//   flush      in   discard all stored entries and any concurrent input
//   out_valid  out  output entry valid
//   out_ready  in   consumer takes the output this cycle
//   ImmExtOut  out  [DATA_W-1:0] generated operand
//   out_tag    out  [TAG_W-1:0]  tag of ImmExtOut
//   out_err    out  entry came from an illegal ImmMode
// -----------------------------------------------------------------------------
module imm_ext_pipe #(
    parameter int DATA_W = 32,
    parameter int TAG_W  = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       Instr,
    input  logic [DATA_W-1:0] PCPlus4,
    input  logic [2:0]        ImmMode,
    input  logic [TAG_W-1:0]  in_tag,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] ImmExtOut,
    output logic [TAG_W-1:0]  out_tag,
    output logic              out_err
);

    localparam int ENT_W = DATA_W + TAG_W + 1;

    // ------------------------------------------------------------------
    // Input-side operand generation
    // ------------------------------------------------------------------
    logic [15:0]       imm;
    logic [63:0]       zext64;
    logic [63:0]       sext64;
    logic [63:0]       lui64;
    logic [63:0]       shamt64;
    logic [63:0]       br64;
    logic [DATA_W-1:0] op_d;
    logic              err_d;
    logic [ENT_W-1:0]  in_entry;

    assign imm     = Instr[15:0];
    assign zext64  = {48'h0, imm};
    assign sext64  = {{48{imm[15]}}, imm};
    // lui result is sign-extended from bit 31; truncation handles DATA_W=32
    assign lui64   = {{32{imm[15]}}, imm, 16'h0000};
    assign shamt64 = {59'h0, Instr[10:6]};
    assign br64    = sext64 << 2;

    always_comb begin
        op_d  = '0;
        err_d = 1'b0;
        case (ImmMode)
            3'd0:    op_d = zext64[DATA_W-1:0];
            3'd1:    op_d = sext64[DATA_W-1:0];
            3'd2:    op_d = lui64[DATA_W-1:0];
            3'd3:    op_d = shamt64[DATA_W-1:0];
            3'd4:    op_d = br64[DATA_W-1:0];
            3'd5:    op_d = {PCPlus4[DATA_W-1:28], Instr[25:0], 2'b00};
            default: err_d = 1'b1;
        endcase
    end

    assign in_entry = {op_d, in_tag, err_d};

    // Fields never consumed by any mode
    logic unused_bits;
    assign unused_bits = ^{Instr[31:26], PCPlus4[27:0]};

    // ------------------------------------------------------------------
    // Storage and handshake
    // ------------------------------------------------------------------
    logic             in_fire;
    logic             out_fire;
    logic [ENT_W-1:0] out_q, out_d;
    logic             out_valid_q, out_valid_d;

    assign in_fire  = in_valid && in_ready;
    assign out_fire = out_valid_q && out_ready;

    assign out_valid                      = out_valid_q;
    assign {ImmExtOut, out_tag, out_err}  = out_q;

`ifdef IMM_EXT_PIPE_SKID_EN
    logic [ENT_W-1:0] skid_q, skid_d;
    logic             skid_valid_q, skid_valid_d;
    logic             in_ready_q, in_ready_d;

    // The skid register is only ever occupied while the output register is,
    // so "fewer than two stored" is simply "skid empty".
    assign in_ready   = in_ready_q;
    assign in_ready_d = !skid_valid_d;

    always_comb begin
        out_d        = out_q;
        out_valid_d  = out_valid_q;
        skid_d       = skid_q;
        skid_valid_d = skid_valid_q;
        if (flush) begin
            out_valid_d  = 1'b0;
            skid_valid_d = 1'b0;
        end else if (skid_valid_q) begin
            // Full: in_ready is low, only draining can happen
            if (out_fire) begin
                out_d        = skid_q;
                skid_valid_d = 1'b0;
            end
        end else if (out_valid_q) begin
            if (in_fire && out_fire) begin
                out_d = in_entry;
            end else if (out_fire) begin
                out_valid_d = 1'b0;
            end else if (in_fire) begin
                // Stall arrived with an accept in flight: park it
                skid_d       = in_entry;
                skid_valid_d = 1'b1;
            end
        end else if (in_fire) begin
            out_d       = in_entry;
            out_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_q        <= '0;
            out_valid_q  <= 1'b0;
            skid_q       <= '0;
            skid_valid_q <= 1'b0;
            in_ready_q   <= 1'b1;
        end else begin
            out_q        <= out_d;
            out_valid_q  <= out_valid_d;
            skid_q       <= skid_d;
            skid_valid_q <= skid_valid_d;
            in_ready_q   <= in_ready_d;
        end
    end
`else
    assign in_ready = !out_valid_q || out_ready;

    always_comb begin
        out_d       = out_q;
        out_valid_d = out_valid_q;
        if (flush) begin
            out_valid_d = 1'b0;
        end else if (in_fire) begin
            out_d       = in_entry;
            out_valid_d = 1'b1;
        end else if (out_fire) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_q       <= '0;
            out_valid_q <= 1'b0;
        end else begin
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
        end
    end
`endif

endmodule

// File: tb/tb_imm_ext_pipe.sv
module tb_imm_ext_pipe;

`ifdef IMM_EXT_PIPE_SKID_EN
    localparam int CAP = 2;
`else
    localparam int CAP = 1;
`endif

    logic        clk = 1'b0;
    logic        reset;

    // 32-bit instance
    logic        in_valid, in_ready, flush, out_valid, out_ready, out_err;
    logic [31:0] Instr, PCPlus4, ImmExtOut;
    logic [2:0]  ImmMode;
    logic [4:0]  in_tag, out_tag;

    // 64-bit instance
    logic        in_valid64, in_ready64, flush64, out_valid64, out_ready64, out_err64;
    logic [31:0] Instr64;
    logic [63:0] PCPlus4_64, ImmExtOut64;
    logic [2:0]  ImmMode64;
    logic [4:0]  in_tag64, out_tag64;

    int tests_run    = 0;
    int tests_failed = 0;

    logic       in_acc, out_acc;
    logic [4:0] obs_tag;
    int         next_tag, got;
    logic       seen_valid;
    logic [31:0] exp_m [7];

    always #5 clk = ~clk;

    imm_ext_pipe #(.DATA_W(32), .TAG_W(5)) dut32 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .Instr(Instr), .PCPlus4(PCPlus4), .ImmMode(ImmMode), .in_tag(in_tag),
        .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
        .ImmExtOut(ImmExtOut), .out_tag(out_tag), .out_err(out_err)
    );

    imm_ext_pipe #(.DATA_W(64), .TAG_W(5)) dut64 (
        .clk(clk), .reset(reset), .in_valid(in_valid64), .in_ready(in_ready64),
        .Instr(Instr64), .PCPlus4(PCPlus4_64), .ImmMode(ImmMode64), .in_tag(in_tag64),
        .flush(flush64), .out_valid(out_valid64), .out_ready(out_ready64),
        .ImmExtOut(ImmExtOut64), .out_tag(out_tag64), .out_err(out_err64)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
        $display("[TB] check %s observed %h expected %h", tag, obs, exp);
    endtask

    // Inputs are set just after a rising edge; sample handshake state, then
    // advance through the next rising edge.
    task automatic cyc();
        #1;
        in_acc  = in_valid && in_ready;
        out_acc = out_valid && out_ready;
        obs_tag = out_tag;
        @(posedge clk);
        #1;
    endtask

    initial begin
        exp_m[0] = 32'h0000FFC4;
        exp_m[1] = 32'hFFFFFFC4;
        exp_m[2] = 32'hFFC40000;
        exp_m[3] = 32'h0000001F;
        exp_m[4] = 32'hFFFFFF10;
        exp_m[5] = 32'h4007FF10;
        exp_m[6] = 32'h00000000;

        reset = 1'b1;
        in_valid = 0; Instr = 0; PCPlus4 = 0; ImmMode = 0; in_tag = 0; flush = 0; out_ready = 1;
        in_valid64 = 0; Instr64 = 0; PCPlus4_64 = 0; ImmMode64 = 0; in_tag64 = 0;
        flush64 = 0; out_ready64 = 1;

        // ---------------- reset state ----------------
        #2;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_imm", ImmExtOut, 0);
        chk("rst_tag", out_tag, 0);
        chk("rst_err", out_err, 0);
        chk("rst_in_ready", in_ready, 1);
        @(posedge clk); #1;
        reset = 1'b0;

        // ---------------- all modes ----------------
        Instr = 32'h8C01_FFC4; PCPlus4 = 32'h4000_0010; out_ready = 1;
        for (int m = 0; m < 7; m++) begin
            in_valid = 1; ImmMode = 3'(m); in_tag = 5'(m + 1);
            cyc();
            chk($sformatf("mode%0d_valid", m), out_valid, 1);
            chk($sformatf("mode%0d_imm", m), ImmExtOut, exp_m[m]);
            chk($sformatf("mode%0d_err", m), out_err, (m == 6) ? 1 : 0);
            chk($sformatf("mode%0d_tag", m), out_tag, m + 1);
        end
        in_valid = 0;
        cyc();
        chk("modes_drained", out_valid, 0);

        // ---------------- backpressure ----------------
        ImmMode = 3'd1;
        out_ready = 0; next_tag = 1;
        for (int c = 0; c < 3; c++) begin
            in_valid = (next_tag <= 4); in_tag = 5'(next_tag);
            cyc();
            if (in_acc) next_tag++;
        end
        chk("bp_accepts_while_stalled", next_tag - 1, CAP);
        chk("bp_in_ready_low", in_ready, 0);
        out_ready = 1; got = 0;
        for (int c = 0; c < 20 && got < 4; c++) begin
            in_valid = (next_tag <= 4); in_tag = 5'(next_tag);
            cyc();
            if (in_acc) next_tag++;
            if (out_acc) begin
                chk($sformatf("bp_order%0d", got + 1), obs_tag, got + 1);
                got++;
            end
        end
        in_valid = 0;
        chk("bp_all_out", got, 4);
        #1;
        chk("bp_empty", out_valid, 0);
        @(posedge clk); #1;

        // ---------------- flush ----------------
        out_ready = 0;
        for (int c = 0; c < CAP; c++) begin
            in_valid = 1; in_tag = 5'(7 + c);
            cyc();
        end
        in_valid = 1; in_tag = 5'd9; flush = 1;
        cyc();
        flush = 0; in_valid = 0;
        chk("flush_out_valid", out_valid, 0);
        chk("flush_in_ready", in_ready, 1);
        out_ready = 1; seen_valid = 0;
        for (int c = 0; c < 3; c++) begin
            cyc();
            if (out_valid) seen_valid = 1;
        end
        chk("flush_no_ghost", seen_valid, 0);

        // ---------------- simultaneous transfer ----------------
        out_ready = 0; in_valid = 1; in_tag = 5'd10;
        cyc();
        chk("sim_first_stored", out_tag, 10);
        in_tag = 5'd11; out_ready = 1;
        cyc();
        chk("sim_both_fired", {in_acc, out_acc}, 2'b11);
        chk("sim_valid_kept", out_valid, 1);
        chk("sim_new_tag", out_tag, 11);
        in_valid = 0;
        cyc();
        chk("sim_second_out", obs_tag, 11);

        // ---------------- asynchronous reset ----------------
        out_ready = 0;
        for (int c = 0; c < CAP; c++) begin
            in_valid = 1; in_tag = 5'(12 + c);
            cyc();
        end
        in_valid = 0;
        chk("ar_pre_valid", out_valid, 1);
        #2; reset = 1; #1;
        chk("ar_out_valid", out_valid, 0);
        chk("ar_imm", ImmExtOut, 0);
        chk("ar_in_ready", in_ready, 1);
        reset = 0;
        @(posedge clk); #1;
        in_valid = 1; in_tag = 5'd14; ImmMode = 3'd0;
        cyc();
        in_valid = 0;
        chk("ar_first_valid", out_valid, 1);
        chk("ar_first_tag", out_tag, 14);
        chk("ar_first_imm", ImmExtOut, 32'h0000FFC4);
        out_ready = 1;
        cyc();

        // ---------------- DATA_W = 64 ----------------
        in_valid64 = 1; Instr64 = 32'h0000_8000; ImmMode64 = 3'd2; in_tag64 = 5'd3;
        @(posedge clk); #1;
        chk("w64_lui_valid", out_valid64, 1);
        chk("w64_lui", ImmExtOut64, 64'hFFFFFFFF80000000);
        Instr64 = 32'h8C01_FFC4; ImmMode64 = 3'd5; PCPlus4_64 = 64'h1234_5678_9ABC_DEF0;
        @(posedge clk); #1;
        chk("w64_jump", ImmExtOut64, 64'h1234_5678_9007_FF10);
        ImmMode64 = 3'd4;
        @(posedge clk); #1;
        chk("w64_branch", ImmExtOut64, 64'hFFFFFFFFFFFFFF10);
        in_valid64 = 0;
        @(posedge clk); #1;

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
